// File: rtl/refill_controller.sv
`default_nettype none
// ============================================================================
//  Module      : refill_controller
//  Description : Memory-side refill engine behind the cache controller.
//                Fetches a 4-word block critical-word-first over a word-wide
//                req/ack memory port, returns it with a one-cycle ready pulse,
//                and posts write-through stores through a 1-entry buffer that
//                always drains before any refill starts.
//  Revision    : 1.0 - initial release
// ============================================================================
module refill_controller #(
    parameter int WORD_W   = 32,
    parameter int TAG_W    = 7,
    parameter int IDX_W    = 6,
    parameter int OFF_W    = 2,
    parameter int HOLD_CYC = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [TAG_W-1:0]                tag,
    input  logic [IDX_W-1:0]                index,
    input  logic [OFF_W-1:0]                offset,
    input  logic                            miss,
    input  logic                            wr_en,
    input  logic [WORD_W-1:0]               wr_data,
    output logic                            ready,
    output logic [(WORD_W<<OFF_W)-1:0]      block_data,
    output logic                            busy,
    output logic                            wr_overflow,
    output logic                            mem_req,
    output logic                            mem_we,
    output logic [TAG_W+IDX_W+OFF_W-1:0]    mem_addr,
    output logic [WORD_W-1:0]               mem_wdata,
    input  logic [WORD_W-1:0]               mem_rdata,
    input  logic                            mem_ack
);

    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
    localparam int BLK_W  = WORD_W << OFF_W;
    localparam int WORDS  = 1 << OFF_W;
    localparam int HC_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [2:0]        state_q,       state_d;
    logic [OFF_W-1:0]  beat_q,        beat_d;
    logic [HC_W-1:0]   hold_cnt_q,    hold_cnt_d;
    logic [TAG_W-1:0]  base_tag_q,    base_tag_d;
    logic [IDX_W-1:0]  base_idx_q,    base_idx_d;
    logic [OFF_W-1:0]  base_off_q,    base_off_d;
    logic [BLK_W-1:0]  block_q,       block_d;
    logic              wb_valid_q,    wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q,     wb_addr_d;
    logic [WORD_W-1:0] wb_data_q,     wb_data_d;
    logic              wr_overflow_q, wr_overflow_d;

    logic              wb_drain;
    logic [OFF_W-1:0]  fill_word;

    // Buffer frees up on the very cycle its write is acknowledged, so a
    // store arriving then is accepted instead of dropped.
    assign wb_drain  = (state_q == S_WRITE) && mem_ack;
    // Critical word first: the beat count walks the block modulo its size.
    assign fill_word = base_off_q + beat_q;

    // Next-state logic: FSM, beat/hold counters, block assembly, write buffer.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        hold_cnt_d    = hold_cnt_q;
        base_tag_d    = base_tag_q;
        base_idx_d    = base_idx_q;
        base_off_d    = base_off_q;
        block_d       = block_q;
        wb_valid_d    = wb_valid_q;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;
        wr_overflow_d = 1'b0;

        if (wb_drain) begin
            wb_valid_d = 1'b0;
        end
        if (wr_en) begin
            if (!wb_valid_q || wb_drain) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = {tag, index, offset};
                wb_data_d  = wr_data;
            end else begin
                wr_overflow_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (wb_valid_q) begin
                    state_d = S_WRITE;
                end else if (miss) begin
                    base_tag_d = tag;
                    base_idx_d = index;
                    base_off_d = offset;
                    beat_d     = '0;
                    state_d    = S_FILL;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (fill_word == OFF_W'(k)) begin
                            block_d[k*WORD_W +: WORD_W] = mem_rdata;
                        end
                    end
                    beat_d = beat_q + 1'b1;
                    if (beat_q == OFF_W'(WORDS - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                hold_cnt_d = '0;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt_q == HC_W'(HOLD_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory port drive; address and data are zero whenever no request is up.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_addr_q;
                mem_wdata = wb_data_q;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {base_tag_q, base_idx_q, fill_word};
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign ready       = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE) || wb_valid_q;
    assign wr_overflow = wr_overflow_q;
    assign block_data  = block_q;

    // State registers with synchronous reset; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            hold_cnt_q    <= '0;
            base_tag_q    <= '0;
            base_idx_q    <= '0;
            base_off_q    <= '0;
            block_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
            wr_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            hold_cnt_q    <= hold_cnt_d;
            base_tag_q    <= base_tag_d;
            base_idx_q    <= base_idx_d;
            base_off_q    <= base_off_d;
            block_q       <= block_d;
            wb_valid_q    <= wb_valid_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            wr_overflow_q <= wr_overflow_d;
        end
    end

endmodule
`default_nettype wire
